fp_minmax_seq: RTL

Sequencer that computes the minimum or maximum of an N-element stream of floating-point values. It is the initiator side of the FPU min/max start/done interface. It accepts operands over a valid/ready stream, keeps a running accumulator, and issues one pairwise compare to an external min/max unit per new element. It sits between a vector/DMA source and the FPU, so the pairwise unit stays purely per-operation.

---
 rtl/fp_minmax_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fp_minmax_seq.sv
// fp_minmax_seq
//
// Purpose:
//   Reduces an N-element stream of floating-point words to its minimum or
//   maximum. It keeps a running accumulator and hands each new element,
//   paired with the accumulator, to an external pairwise min/max unit over a
//   start/done handshake. Operand values are never inspected here, so NaN and
//   signed-zero behaviour is whatever the external unit implements.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start           begin a reduction (only honoured while idle)
//   max_n_min       1 = maximum, 0 = minimum; latched at start
//   len             element count N; latched at start
//   busy            high while a reduction is in progress
//   done            one-cycle pulse when res carries a new result
//   res             result, held until the next done
//   in_valid/in_ready/in_data   element stream (valid/ready)
//   fu_start        one-cycle compare request to the min/max unit
//   fu_max_n_min    operation select presented to the unit
//   fu_op_a/fu_op_b accumulator / new element, stable until fu_done
//   fu_done/fu_res  unit completion pulse and result
//
// All outputs come straight from registers.
module fp_minmax_seq #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              max_n_min,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              fu_start,
  output logic              fu_max_n_min,
  output logic [DATA_W-1:0] fu_op_a,
  output logic [DATA_W-1:0] fu_op_b,
  input  logic              fu_done,
  input  logic [DATA_W-1:0] fu_res
);

  // Quiet NaN with sign 0, all-ones exponent and the top mantissa bit set.
  localparam logic [DATA_W-1:0] CANON_NAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(DATA_W-EXP_W-2){1'b0}}};

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_NEXT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                mnm_q, mnm_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                fu_start_q, fu_start_d;

  logic                stream_hs;

  // in_ready_q is exactly what the source sees, so the handshake is judged
  // against the registered copy.
  assign stream_hs = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    res_d      = res_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    mnm_d      = mnm_q;
    done_d     = 1'b0;
    fu_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty reduction: no stream traffic, result is the canonical NaN.
            res_d   = CANON_NAN;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            mnm_d   = max_n_min;
            rem_d   = len - LEN_ONE;
            state_d = S_FIRST;
          end
        end
      end

      S_FIRST: begin
        if (stream_hs) begin
          acc_d = in_data;
          if (rem_q == '0) begin
            // Single element passes through untouched, even a NaN.
            res_d   = in_data;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (stream_hs) begin
          op_a_d     = acc_q;
          op_b_d     = in_data;
          fu_start_d = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // Operands stay frozen here; only the unit's completion moves us on.
        if (fu_done) begin
          acc_d = fu_res;
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            res_d   = fu_res;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    // busy is already low in the DONE cycle, where done is high.
    busy_d     = (state_d == S_FIRST) || (state_d == S_NEXT) ||
                 (state_d == S_WAIT);
    in_ready_d = (state_d == S_FIRST) || (state_d == S_NEXT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      res_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      mnm_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      fu_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      res_q      <= res_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      mnm_q      <= mnm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      fu_start_q <= fu_start_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign res          = res_q;
  assign in_ready     = in_ready_q;
  assign fu_start     = fu_start_q;
  assign fu_max_n_min = mnm_q;
  assign fu_op_a      = op_a_q;
  assign fu_op_b      = op_b_q;

endmodule
